// File: rtl/qosc_pkg.sv
// Shared types and arithmetic helpers for the quadrature oscillator core:
// FSM state encoding, config register addresses, rounding and saturation.
package qosc_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_WB, S_E0, S_E1, S_ADJ
    } qosc_state_t;

    localparam logic [2:0] CFG_RE_COEFF = 3'd0;
    localparam logic [2:0] CFG_IM_COEFF = 3'd1;
    localparam logic [2:0] CFG_POWER    = 3'd2;
    localparam logic [2:0] CFG_RE_INIT  = 3'd3;
    localparam logic [2:0] CFG_IM_INIT  = 3'd4;

    // Round-half-up of a Q2.(2w-2) product back to Q1.(w-1).
    function automatic logic signed [31:0] round_q(input logic signed [31:0] x, input int w);
        return (x + (32'sd1 <<< (w - 2))) >>> (w - 1);
    endfunction

    function automatic logic signed [31:0] sat_q(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/qosc_core_param_mac.sv
// Single shared signed multiplier with two result accumulators; the FSM state
// selects the operand pair and whether the product loads, adds or subtracts.
module qosc_mac
    import qosc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  qosc_state_t           state,
    input  logic signed [W-1:0]   re,
    input  logic signed [W-1:0]   im,
    input  logic signed [W-1:0]   cre,
    input  logic signed [W-1:0]   cim,
    output logic signed [2*W:0]   acc_a,
    output logic signed [2*W:0]   acc_b
);

    logic signed [W-1:0]   op_x, op_y;
    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   prod_x;

    always_comb begin
        op_x = re;
        op_y = cre;
        case (state)
            S_M1:    begin op_x = im; op_y = cim; end
            S_M2:    begin op_x = re; op_y = cim; end
            S_M3:    begin op_x = im; op_y = cre; end
            S_E0:    begin op_x = re; op_y = re;  end
            S_E1:    begin op_x = im; op_y = im;  end
            default: begin op_x = re; op_y = cre; end
        endcase
    end

    assign prod   = op_x * op_y;
    assign prod_x = {prod[2*W-1], prod};

    // acc_a carries the real part (later the energy), acc_b the imaginary part
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a <= '0;
            acc_b <= '0;
        end else begin
            case (state)
                S_M0:    acc_a <= prod_x;
                S_M1:    acc_a <= acc_a - prod_x;
                S_M2:    acc_b <= prod_x;
                S_M3:    acc_b <= acc_b + prod_x;
                S_E0:    acc_a <= prod_x;
                S_E1:    acc_a <= acc_a + prod_x;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/qosc_core_param.sv
// Quadrature oscillator core: rotates (re,im) by a shadowed coefficient pair per tick.
// Optional amplitude control is enabled by defining QOSC_AGC_EN.
module qosc_core_param
    import qosc_pkg::*;
#(
    parameter int           W            = 8,
    parameter logic [W-1:0] RE_COEFF_RST = 8'h7d,
    parameter logic [W-1:0] IM_COEFF_RST = 8'h1b,
    parameter logic [W-1:0] POWER_RST    = 8'h40,
    parameter logic [W-1:0] RE_INIT_RST  = 8'h20,
    parameter logic [W-1:0] IM_INIT_RST  = 8'h00,
    parameter int           AGC_SHIFT    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_i,
    input  logic         load,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [2:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    output logic [W-1:0] accu_re,
    output logic [W-1:0] accu_im,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun
);

    qosc_state_t         state;
    logic [W-1:0]        re_coeff, im_coeff, power, re_init, im_init;
    logic [W-1:0]        cre_sh, cim_sh;
    logic signed [W-1:0] mac_re, mac_im;
    logic signed [2*W:0] acc_a, acc_b;
    logic signed [W-1:0] wb_re, wb_im;

    assign cfg_ready = ~load;
    assign busy      = (state != S_IDLE);

    assign wb_re = W'(sat_q(round_q(32'(acc_a), W), W));
    assign wb_im = W'(sat_q(round_q(32'(acc_b), W), W));

`ifdef QOSC_AGC_EN
    logic signed [W-1:0] n_re, n_im, adj_re, adj_im;
    logic signed [31:0]  e_q, p_q;
    logic                e_lo, e_hi;

    function automatic logic [W-1:0] agc_step(input logic signed [W-1:0] x,
                                              input logic up, input logic dn);
        logic signed [31:0] xe, d;
        xe = 32'(x);
        d  = xe >>> AGC_SHIFT;
        if (up)      xe = xe + d;
        else if (dn) xe = xe - d;
        return W'(sat_q(xe, W));
    endfunction

    // acc_a holds re'^2 + im'^2 (never negative) while in ADJ
    assign e_q    = 32'(acc_a) >>> (W - 2);
    assign p_q    = 32'(power);
    assign e_lo   = (e_q < p_q);
    assign e_hi   = (e_q > p_q);
    assign adj_re = agc_step(n_re, e_lo, e_hi);
    assign adj_im = agc_step(n_im, e_lo, e_hi);
    assign mac_re = (state == S_E0 || state == S_E1) ? n_re : accu_re;
    assign mac_im = (state == S_E0 || state == S_E1) ? n_im : accu_im;
`else
    logic unused_power;
    assign unused_power = ^power;
    assign mac_re = accu_re;
    assign mac_im = accu_im;
`endif

    qosc_mac #(.W(W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .state (state),
        .re    (mac_re),
        .im    (mac_im),
        .cre   (cre_sh),
        .cim   (cim_sh),
        .acc_a (acc_a),
        .acc_b (acc_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            re_coeff  <= RE_COEFF_RST;
            im_coeff  <= IM_COEFF_RST;
            power     <= POWER_RST;
            re_init   <= RE_INIT_RST;
            im_init   <= IM_INIT_RST;
            cre_sh    <= RE_COEFF_RST;
            cim_sh    <= IM_COEFF_RST;
            accu_re   <= RE_INIT_RST;
            accu_im   <= IM_INIT_RST;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef QOSC_AGC_EN
            n_re      <= '0;
            n_im      <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (cfg_valid && cfg_ready) begin
                case (cfg_addr)
                    CFG_RE_COEFF: re_coeff <= cfg_data;
                    CFG_IM_COEFF: im_coeff <= cfg_data;
                    CFG_POWER:    power    <= cfg_data;
                    CFG_RE_INIT:  re_init  <= cfg_data;
                    CFG_IM_INIT:  im_init  <= cfg_data;
                    default: ;
                endcase
            end
            if (load) begin
                state   <= S_IDLE;
                accu_re <= re_init;
                accu_im <= im_init;
                overrun <= 1'b0;
            end else begin
                if (tick_i && state != S_IDLE) overrun <= 1'b1;
                case (state)
                    S_IDLE: if (tick_i) begin
                        // shadows take the pre-write value if a cfg write lands this cycle
                        cre_sh <= re_coeff;
                        cim_sh <= im_coeff;
                        state  <= S_M0;
                    end
                    S_M0: state <= S_M1;
                    S_M1: state <= S_M2;
                    S_M2: state <= S_M3;
                    S_M3: state <= S_WB;
`ifdef QOSC_AGC_EN
                    S_WB: begin
                        n_re  <= wb_re;
                        n_im  <= wb_im;
                        state <= S_E0;
                    end
                    S_E0: state <= S_E1;
                    S_E1: state <= S_ADJ;
                    S_ADJ: begin
                        accu_re   <= adj_re;
                        accu_im   <= adj_im;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
`else
                    S_WB: begin
                        accu_re   <= wb_re;
                        accu_im   <= wb_im;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
